spm_row_accumulator: RTL and testbench
======================================

SPM_ROW_ACCUMULATOR -- requirements
Module: spm_row_accumulator

Interface
REQ-001 Parameter DATA_W, default 32, width of product input and row sum output.
REQ-002 Parameter ROW_W, default 32, width of row IDs.
REQ-003 Parameter FIFO_DEPTH, default 4, output FIFO entries; power of two, at least 2.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 spmv_init  input  1  start of a new SpMV pass; same effect as rst.
REQ-007 in_valid  input  1  product beat valid from the channel multiplier pipeline.
REQ-008 in_ready  output  1  accumulator accepts a beat this cycle.
REQ-009 in_row_id  input  ROW_W  row ID of the beat, from the CISR decoder path.
REQ-010 in_product  input  DATA_W  matrix value times vector value, two's complement.
REQ-011 in_last  input  1  final beat of the pass.
REQ-012 out_valid  output  1  a completed (row ID, sum) pair is presented.
REQ-013 out_ready  input  1  consumer takes the pair.
REQ-014 out_row_id  output  ROW_W  row ID of the presented pair.
REQ-015 out_sum  output  DATA_W  row sum of the presented pair.
REQ-016 done  output  1  pass complete and all pairs drained.
REQ-017 row_order_err  output  1  sticky flag: row ID went backwards within a pass.

Function
REQ-018 A beat is accepted when in_valid and in_ready are both high in the same cycle.
REQ-019 States: IDLE (no open row), ACCUM (open row held in cur_row/acc), LAST_FLUSH (final single-beat row still pending), DRAIN (waiting for FIFO empty), DONE.
REQ-020 in_ready is high only in IDLE or ACCUM with FIFO count < FIFO_DEPTH; it is computed from registered count, with no same-cycle pop pass-through.
REQ-021 IDLE, accepted beat: cur_row<=in_row_id, acc<=in_product, go to ACCUM.
REQ-022 ACCUM, accepted beat with in_row_id==cur_row: acc<=acc+in_product.
REQ-023 ACCUM, accepted beat with in_row_id!=cur_row: push (cur_row,acc), then cur_row<=in_row_id, acc<=in_product.
REQ-024 in_row_id<cur_row on the REQ-023 transition sets row_order_err; the beat is still processed normally.
REQ-025 in_last on the REQ-021 or REQ-022 transition: push the updated pair and go to DRAIN.
REQ-026 in_last on the REQ-023 transition: push the old pair, load the new row, and go to LAST_FLUSH.
REQ-027 LAST_FLUSH pushes the held pair when the FIFO is not full and goes to DRAIN; otherwise it holds.
REQ-028 DRAIN goes to DONE when the FIFO count is 0; done is high exactly in DONE, which is held until rst/spmv_init.
REQ-029 Only rows with at least one beat produce a pair; rows with zero length emit nothing.
REQ-030 Latency: out_valid rises on the cycle after the push cycle when the FIFO was empty.
REQ-031 The FIFO is first-in first-out; pop occurs when out_valid and out_ready are both high. Simultaneous push and pop are legal, and count then stays unchanged.
REQ-032 out_row_id/out_sum are held stable while out_valid is high and out_ready is low.
REQ-033 Addition is modulo 2^DATA_W unless ACC_SATURATE_EN is defined (REQ-037).

Reset
REQ-034 When rst or spmv_init is high at a clock edge, the block goes to IDLE, clears the FIFO (count 0, pointers 0), clears cur_row and acc to 0, and clears row_order_err; this applies mid-pass, and any pending pairs are discarded.
REQ-035 Output values during reset and on the following cycle: in_ready=1, out_valid=0, out_row_id=0, out_sum=0, done=0, row_order_err=0.
REQ-036 rst and spmv_init take priority over any simultaneous accepted beat or pop.

Configuration
REQ-037 Macro ACC_SATURATE_EN, when defined, makes every acc update use a signed saturating add, clamping to 2^(DATA_W-1)-1 or -2^(DATA_W-1); when undefined, the add wraps.

Verification
REQ-038 Beats (row 0,3),(0,4),(2,5 last), out_ready=1: pairs (0,7) then (2,5) are output, and done rises once the FIFO is empty.
REQ-039 FIFO_DEPTH=4, out_ready=0, beats on rows 1..6 with one beat each: in_ready drops after the 4th pair is pushed, and no beat is lost after out_ready goes to 1.
REQ-040 Beats (5,1),(3,1 last): row_order_err=1, pairs (5,1),(3,1) are output, and the LAST_FLUSH path is exercised.
REQ-041 spmv_init asserted mid-pass with 2 pairs queued: the next cycle shows out_valid=0, done=0, in_ready=1, and the new pass starts clean.
REQ-042 DATA_W=32, beats (0,0x7FFFFFFF),(0,1 last): out_sum=0x80000000 without ACC_SATURATE_EN and 0x7FFFFFFF with it.
REQ-043 out_ready toggling every cycle during a full push stream: pairs stay in order, with no duplicates and no drops.

Source files
------------

// File: rtl/spm_row_accumulator.sv
// ---------------------------------------------------------------------------
// spm_row_accumulator
//
// Collapses a stream of (row ID, product) beats from the SpMV multiplier
// pipeline into one (row ID, row sum) pair per non-empty row. Completed pairs
// are queued in a small output FIFO. A pass ends on the beat flagged in_last.
// Once every pair has drained, done is raised and held until the next
// rst/spmv_init.
//
// Build option: define ACC_SATURATE_EN to use signed saturating row sums.
// Without it, sums wrap modulo 2^DATA_W.
//
// Ports
//   clk            rising-edge clock
//   rst            synchronous active-high reset
//   spmv_init      start of a new pass (same effect as rst)
//   in_valid       product beat valid
//   in_ready       accumulator accepts a beat this cycle
//   in_row_id      row ID of the beat
//   in_product     two's complement product
//   in_last        final beat of the pass
//   out_valid      a (row ID, sum) pair is presented
//   out_ready      consumer takes the pair
//   out_row_id     row ID of the presented pair
//   out_sum        row sum of the presented pair
//   done           pass complete and FIFO drained
//   row_order_err  sticky: row ID decreased within the pass
// ---------------------------------------------------------------------------
module spm_row_accumulator #(
    parameter int DATA_W     = 32,
    parameter int ROW_W      = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spmv_init,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ROW_W-1:0]  in_row_id,
    input  logic [DATA_W-1:0] in_product,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ROW_W-1:0]  out_row_id,
    output logic [DATA_W-1:0] out_sum,
    output logic              done,
    output logic              row_order_err
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ACCUM      = 3'd1,
        ST_LAST_FLUSH = 3'd2,
        ST_DRAIN      = 3'd3,
        ST_DONE       = 3'd4
    } state_t;

    state_t             state_r, state_nxt_s;
    logic [ROW_W-1:0]   cur_row_r, cur_row_nxt_s;
    logic [DATA_W-1:0]  acc_r, acc_nxt_s;
    logic               row_order_err_r, err_set_s;

    logic [ROW_W-1:0]   row_mem_r [FIFO_DEPTH];
    logic [DATA_W-1:0]  sum_mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0]   count_r;

    logic               not_full_s, accept_s, pop_s, push_s;
    logic [ROW_W-1:0]   push_row_s;
    logic [DATA_W-1:0]  push_sum_s, acc_sum_s;

    // Row-sum adder: wraps, or clamps to the signed range when saturation is built in.
    function automatic logic [DATA_W-1:0] acc_add(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
        logic [DATA_W-1:0] sum_v;
        sum_v = a + b;
`ifdef ACC_SATURATE_EN
        // Overflow only when both operands share a sign the result lacks.
        if ((a[DATA_W-1] == b[DATA_W-1]) && (sum_v[DATA_W-1] != a[DATA_W-1])) begin
            sum_v = a[DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                : {1'b0, {(DATA_W-1){1'b1}}};
        end
`endif
        return sum_v;
    endfunction

    // Handshake terms come from registered state only, so a pop in this cycle never frees a slot early.
    assign not_full_s = (count_r < CNT_W'(FIFO_DEPTH));
    assign in_ready   = ((state_r == ST_IDLE) || (state_r == ST_ACCUM)) && not_full_s;
    assign accept_s   = in_valid && in_ready;
    assign out_valid  = (count_r != {CNT_W{1'b0}});
    assign pop_s      = out_valid && out_ready;
    assign out_row_id = row_mem_r[rd_ptr_r];
    assign out_sum    = sum_mem_r[rd_ptr_r];
    assign done       = (state_r == ST_DONE);
    assign row_order_err = row_order_err_r;
    assign acc_sum_s  = acc_add(acc_r, in_product);

    // Next-state, open-row update and FIFO push decisions.
    always_comb begin
        state_nxt_s   = state_r;
        cur_row_nxt_s = cur_row_r;
        acc_nxt_s     = acc_r;
        err_set_s     = 1'b0;
        push_s        = 1'b0;
        push_row_s    = cur_row_r;
        push_sum_s    = acc_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    cur_row_nxt_s = in_row_id;
                    acc_nxt_s     = in_product;
                    if (in_last) begin
                        // Single-beat pass: emit immediately.
                        push_s      = 1'b1;
                        push_row_s  = in_row_id;
                        push_sum_s  = in_product;
                        state_nxt_s = ST_DRAIN;
                    end else begin
                        state_nxt_s = ST_ACCUM;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (accept_s && (in_row_id == cur_row_r)) begin
                    acc_nxt_s = acc_sum_s;
                    if (in_last) begin
                        push_s      = 1'b1;
                        push_sum_s  = acc_sum_s;
                        state_nxt_s = ST_DRAIN;
                    end else begin
                        state_nxt_s = ST_ACCUM;
                    end
                end else if (accept_s) begin
                    // Row change closes the open row; the new beat opens the next one.
                    push_s        = 1'b1;
                    cur_row_nxt_s = in_row_id;
                    acc_nxt_s     = in_product;
                    err_set_s     = (in_row_id < cur_row_r);
                    state_nxt_s   = in_last ? ST_LAST_FLUSH : ST_ACCUM;
                end else begin
                    state_nxt_s = ST_ACCUM;
                end
            end
            ST_LAST_FLUSH: begin
                if (not_full_s) begin
                    push_s      = 1'b1;
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_LAST_FLUSH;
                end
            end
            ST_DRAIN: begin
                if (count_r == {CNT_W{1'b0}}) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_DONE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, open row, error flag and FIFO registers; rst/spmv_init override everything.
    always_ff @(posedge clk) begin
        if (rst || spmv_init) begin
            state_r         <= ST_IDLE;
            cur_row_r       <= {ROW_W{1'b0}};
            acc_r           <= {DATA_W{1'b0}};
            row_order_err_r <= 1'b0;
            wr_ptr_r        <= {PTR_W{1'b0}};
            rd_ptr_r        <= {PTR_W{1'b0}};
            count_r         <= {CNT_W{1'b0}};
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                row_mem_r[i] <= {ROW_W{1'b0}};
                sum_mem_r[i] <= {DATA_W{1'b0}};
            end
        end else begin
            state_r         <= state_nxt_s;
            cur_row_r       <= cur_row_nxt_s;
            acc_r           <= acc_nxt_s;
            row_order_err_r <= row_order_err_r | err_set_s;
            if (push_s) begin
                row_mem_r[wr_ptr_r] <= push_row_s;
                sum_mem_r[wr_ptr_r] <= push_sum_s;
                wr_ptr_r            <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            if (push_s && !pop_s) begin
                count_r <= count_r + CNT_W'(1);
            end else if (pop_s && !push_s) begin
                count_r <= count_r - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_spm_row_accumulator.sv
// ---------------------------------------------------------------------------
// Directed self-checking bench for spm_row_accumulator (default parameters).
// Popped pairs are captured into a queue and compared with hand-written
// expectations after each pass.
// ---------------------------------------------------------------------------
module tb_spm_row_accumulator;

    logic        clk = 1'b0;
    logic        rst, spmv_init, in_valid, in_last, out_ready;
    logic        in_ready, out_valid, done, row_order_err;
    logic [31:0] in_row_id, in_product, out_row_id, out_sum;

    int checks = 0;
    int errors = 0;
    bit tog_mode = 1'b0;

    logic [31:0] got_row[$], got_sum[$], exp_row[$], exp_sum[$];

    always #5 clk = ~clk;

    spm_row_accumulator #(.DATA_W(32), .ROW_W(32), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .spmv_init(spmv_init),
        .in_valid(in_valid), .in_ready(in_ready), .in_row_id(in_row_id),
        .in_product(in_product), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_row_id(out_row_id),
        .out_sum(out_sum), .done(done), .row_order_err(row_order_err)
    );

    // Capture each pair the consumer takes at the coming rising edge.
    always @(negedge clk) begin
        if (rst === 1'b0 && spmv_init === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            got_row.push_back(out_row_id);
            got_sum.push_back(out_sum);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (tog_mode) out_ready = ~out_ready;
    endtask

    task automatic send(input logic [31:0] r, input logic [31:0] p, input logic l);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1; in_row_id = r; in_product = p; in_last = l;
        for (int k = 0; k < 200 && !ok; k++) begin
            ok = (in_ready === 1'b1);
            step();
        end
        in_valid = 1'b0; in_last = 1'b0;
        chk($sformatf("send_accept_row%0d", r), {63'd0, ok}, 64'd1);
    endtask

    task automatic wait_done(input string tag);
        for (int k = 0; k < 400 && done !== 1'b1; k++) step();
        chk(tag, {63'd0, done}, 64'd1);
    endtask

    task automatic init_pass();
        spmv_init = 1'b1;
        step();
        spmv_init = 1'b0;
        got_row.delete(); got_sum.delete();
        exp_row.delete(); exp_sum.delete();
    endtask

    task automatic expect_pair(input logic [31:0] r, input logic [31:0] s);
        exp_row.push_back(r);
        exp_sum.push_back(s);
    endtask

    task automatic check_pairs(input string tag);
        chk({tag, "_count"}, 64'(got_row.size()), 64'(exp_row.size()));
        for (int i = 0; i < exp_row.size(); i++) begin
            if (i < got_row.size()) begin
                chk($sformatf("%s_row%0d", tag, i), 64'(got_row[i]), 64'(exp_row[i]));
                chk($sformatf("%s_sum%0d", tag, i), 64'(got_sum[i]), 64'(exp_sum[i]));
            end
        end
    endtask

    initial begin
        rst = 1'b1; spmv_init = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        out_ready = 1'b0; in_row_id = 32'd0; in_product = 32'd0;

        // Reset values, during reset and on the cycle after release.
        step(); step();
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_row_id", 64'(out_row_id), 64'd0);
        chk("rst_out_sum", 64'(out_sum), 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_err", {63'd0, row_order_err}, 64'd0);
        rst = 1'b0;
        step();
        chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("post_rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("post_rst_done", {63'd0, done}, 64'd0);

        // Latency and hold: single-beat pass, consumer stalled.
        send(32'd7, 32'd9, 1'b1);
        chk("lat_out_valid", {63'd0, out_valid}, 64'd1);
        chk("lat_row", 64'(out_row_id), 64'd7);
        chk("lat_sum", 64'(out_sum), 64'd9);
        step(); step();
        chk("hold_out_valid", {63'd0, out_valid}, 64'd1);
        chk("hold_row", 64'(out_row_id), 64'd7);
        chk("hold_sum", 64'(out_sum), 64'd9);
        chk("hold_done", {63'd0, done}, 64'd0);
        chk("hold_in_ready", {63'd0, in_ready}, 64'd0);
        out_ready = 1'b1;
        wait_done("lat_done");
        expect_pair(32'd7, 32'd9);
        check_pairs("lat");

        // Basic accumulation: (0,3),(0,4),(2,5 last).
        init_pass();
        chk("init_done_low", {63'd0, done}, 64'd0);
        send(32'd0, 32'd3, 1'b0);
        send(32'd0, 32'd4, 1'b0);
        send(32'd2, 32'd5, 1'b1);
        wait_done("basic_done");
        expect_pair(32'd0, 32'd7);
        expect_pair(32'd2, 32'd5);
        check_pairs("basic");
        chk("basic_err", {63'd0, row_order_err}, 64'd0);
        chk("basic_empty", {63'd0, out_valid}, 64'd0);

        // Backpressure: rows 1..6, FIFO fills with four pairs.
        init_pass();
        out_ready = 1'b0;
        for (int r = 1; r <= 5; r++) send(32'(r), 32'(r * 10), 1'b0);
        chk("full_in_ready", {63'd0, in_ready}, 64'd0);
        step(); step();
        chk("full_in_ready_held", {63'd0, in_ready}, 64'd0);
        chk("full_out_valid", {63'd0, out_valid}, 64'd1);
        out_ready = 1'b1;
        send(32'd6, 32'd60, 1'b1);
        wait_done("full_done");
        for (int r = 1; r <= 6; r++) expect_pair(32'(r), 32'(r * 10));
        check_pairs("full");

        // Row order error with last beat opening a new row.
        init_pass();
        chk("init_err_clear", {63'd0, row_order_err}, 64'd0);
        send(32'd5, 32'd1, 1'b0);
        send(32'd3, 32'd1, 1'b1);
        chk("order_err_set", {63'd0, row_order_err}, 64'd1);
        wait_done("order_done");
        expect_pair(32'd5, 32'd1);
        expect_pair(32'd3, 32'd1);
        check_pairs("order");
        chk("order_err_sticky", {63'd0, row_order_err}, 64'd1);

        // spmv_init mid-pass with two pairs queued and an error pending.
        init_pass();
        out_ready = 1'b0;
        send(32'd3, 32'd1, 1'b0);
        send(32'd2, 32'd2, 1'b0);
        send(32'd4, 32'd3, 1'b0);
        chk("mid_out_valid", {63'd0, out_valid}, 64'd1);
        chk("mid_err", {63'd0, row_order_err}, 64'd1);
        init_pass();
        chk("mid_init_out_valid", {63'd0, out_valid}, 64'd0);
        chk("mid_init_done", {63'd0, done}, 64'd0);
        chk("mid_init_in_ready", {63'd0, in_ready}, 64'd1);
        chk("mid_init_err", {63'd0, row_order_err}, 64'd0);
        chk("mid_init_sum", 64'(out_sum), 64'd0);
        out_ready = 1'b1;
        send(32'd4, 32'd10, 1'b0);
        send(32'd4, 32'd5, 1'b1);
        wait_done("restart_done");
        expect_pair(32'd4, 32'd15);
        check_pairs("restart");

        // Overflow in both directions.
        init_pass();
        send(32'd0, 32'h7FFF_FFFF, 1'b0);
        send(32'd0, 32'h0000_0001, 1'b0);
        send(32'd1, 32'h8000_0000, 1'b0);
        send(32'd1, 32'hFFFF_FFFF, 1'b1);
        wait_done("ovf_done");
`ifdef ACC_SATURATE_EN
        expect_pair(32'd0, 32'h7FFF_FFFF);
        expect_pair(32'd1, 32'h8000_0000);
`else
        expect_pair(32'd0, 32'h8000_0000);
        expect_pair(32'd1, 32'h7FFF_FFFF);
`endif
        check_pairs("ovf");

        // Continuous push stream with out_ready toggling every cycle.
        init_pass();
        out_ready = 1'b1;
        tog_mode = 1'b1;
        for (int r = 10; r <= 19; r++) begin
            if (r == 12) send(32'd12, 32'd5, 1'b0);
            send(32'(r), 32'(r + 100), (r == 19) ? 1'b1 : 1'b0);
        end
        wait_done("toggle_done");
        tog_mode = 1'b0;
        for (int r = 10; r <= 19; r++) expect_pair(32'(r), (r == 12) ? 32'd117 : 32'(r + 100));
        check_pairs("toggle");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
